// File: rtl/multi_clk_enable_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators produce
// 1-cycle enables and 50%-duty divided strobes, with lock sequencing after (re)config.
module multi_clk_enable_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int ACC_W       = 24,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  // state    | meaning
  // SETTLE   | counting settle cycles since reset/apply, cfg accepted
  // LOCKED   | all channel settings stable, cfg accepted
  // APPLY    | one cycle after a valid channel update, cfg blocked
  typedef enum logic [1:0] {ST_SETTLE, ST_LOCKED, ST_APPLY} state_t;

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_accept, w_ch_ok, w_apply;

  // Held low combinationally during reset so no transfer can complete then.
  assign cfg_ready = rst_n && (r_state != ST_APPLY);
  assign locked    = (r_state == ST_LOCKED);
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_ch_ok   = (32'(cfg_ch) < NUM_CH);
  assign w_apply   = w_accept && w_ch_ok;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_SETTLE: begin
        if (w_apply)
          w_state_nxt = ST_APPLY;
        else if (r_cnt == CNT_W'(LOCK_CYCLES - 1))
          w_state_nxt = ST_LOCKED;
        else
          w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      ST_LOCKED: begin
        if (w_apply)
          w_state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] r_acc, r_inc;
    logic             r_en, r_ce, r_outclk;
    logic [ACC_W:0]   w_sum;
    logic             w_sel;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_sel = w_apply && (32'(cfg_ch) == g);

    // sync and a fresh config both restart the phase; they may coincide.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc    <= '0;
        r_inc    <= '0;
        r_en     <= 1'b0;
        r_ce     <= 1'b0;
        r_outclk <= 1'b0;
      end else begin
        if (w_sel) begin
          r_inc <= cfg_inc;
          r_en  <= cfg_en;
        end
        if (sync || w_sel || !r_en) begin
          r_acc    <= '0;
          r_ce     <= 1'b0;
          r_outclk <= 1'b0;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
          r_ce  <= w_sum[ACC_W];
          if (w_sum[ACC_W])
            r_outclk <= ~r_outclk;
        end
      end
    end

    assign ce[g]     = r_ce;
    assign outclk[g] = r_outclk;
  end

endmodule

// File: tb/tb_multi_clk_enable_gen.sv
// Directed bench for multi_clk_enable_gen: vector table for the first channel
// programming plus hand-written sequences for lock timing, rates, sync and reset.
module tb_multi_clk_enable_gen;

  logic       refclk;
  logic       rst_n;
  logic       cfg_valid, cfg_ready, cfg_en, sync;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [3:0] ce, outclk;
  logic       locked;

  // three-channel instance so a 2-bit channel number can be out of range
  logic       cfg3_valid, cfg3_ready, cfg3_en;
  logic [1:0] cfg3_ch;
  logic [7:0] cfg3_inc;
  logic [2:0] ce3, outclk3;
  logic       locked3;

  int checks = 0;
  int failures = 0;

  multi_clk_enable_gen #(.NUM_CH(4), .ACC_W(8), .LOCK_CYCLES(16)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en), .sync(sync),
    .ce(ce), .outclk(outclk), .locked(locked));

  multi_clk_enable_gen #(.NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(16)) dut3 (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_inc(cfg3_inc), .cfg_en(cfg3_en), .sync(1'b0),
    .ce(ce3), .outclk(outclk3), .locked(locked3));

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic       vld;
    logic [1:0] ch;
    logic [7:0] inc;
    logic       en;
    logic       sy;
    logic [3:0] ece;
    logic [3:0] eoc;
    logic       elk;
    logic       erdy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] inc, input logic en);
    chk("cfg_ready_before", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_en = en;
    step();
    cfg_valid = 1'b0;
    chk("apply_ready_low", 32'(cfg_ready), 32'd0);
    chk("apply_locked_low", 32'(locked), 32'd0);
  endtask

  task automatic wait_locked();
    int n = 0;
    while (!locked && n < 40) begin
      step();
      n++;
    end
    chk("wait_locked", 32'(locked), 32'd1);
  endtask

  initial begin
    int n_ce1, n_ce0, n_ce2, last1, gap_bad, first1, n_ce3, zero_bad;

    // row k describes the state after k+1 edges from the ch0 accept edge
    tbl[0]  = '{1'b1, 2'd0, 8'd64, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_inc = 8'd0; cfg_en = 1'b0; sync = 1'b0;
    cfg3_valid = 1'b0; cfg3_ch = 2'd0; cfg3_inc = 8'd0; cfg3_en = 1'b0;
    #3;
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // lock timing after reset release
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1)  chk("ready_after_rst", 32'(cfg_ready), 32'd1);
      if (k == 15) chk("locked_at_15", 32'(locked), 32'd0);
      if (k == 16) chk("locked_at_16", 32'(locked), 32'd1);
    end
    chk("idle_ce", 32'(ce), 32'd0);
    chk("idle_outclk", 32'(outclk), 32'd0);

    // ch0 inc=64 from the vector table
    for (int r = 0; r < 13; r++) begin
      cfg_valid = tbl[r].vld; cfg_ch = tbl[r].ch; cfg_inc = tbl[r].inc;
      cfg_en = tbl[r].en; sync = tbl[r].sy;
      step();
      chk($sformatf("tbl%0d_ce", r), 32'(ce), 32'(tbl[r].ece));
      chk($sformatf("tbl%0d_outclk", r), 32'(outclk), 32'(tbl[r].eoc));
      chk($sformatf("tbl%0d_locked", r), 32'(locked), 32'(tbl[r].elk));
      chk($sformatf("tbl%0d_ready", r), 32'(cfg_ready), 32'(tbl[r].erdy));
    end
    cfg_valid = 1'b0; sync = 1'b0;
    step(); step(); step(); step();
    chk("relock_at_16", 32'(locked), 32'd0);
    step();
    chk("relock_at_17", 32'(locked), 32'd1);

    // ch1 inc=3 while ch0 keeps running
    do_cfg(2'd1, 8'd3, 1'b1);
    n_ce1 = 0; n_ce0 = 0; last1 = -1; gap_bad = 0; first1 = -1;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (ce[0]) n_ce0++;
      if (ce[1]) begin
        n_ce1++;
        if (first1 < 0) first1 = k;
        if (last1 >= 0 && (k - last1) != 85 && (k - last1) != 86) gap_bad++;
        last1 = k;
      end
    end
    chk("ch1_pulses_256", 32'(n_ce1), 32'd3);
    chk("ch1_first_pulse", 32'(first1), 32'd86);
    chk("ch1_gap_bad", 32'(gap_bad), 32'd0);
    chk("ch0_pulses_256", 32'(n_ce0), 32'd64);

    // ch2 near-full rate, then zero increment
    do_cfg(2'd2, 8'd255, 1'b1);
    n_ce2 = 0;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (ce[2]) n_ce2++;
    end
    chk("ch2_inc255_pulses", 32'(n_ce2), 32'd255);
    do_cfg(2'd2, 8'd0, 1'b1);
    n_ce2 = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (ce[2] || outclk[2]) n_ce2++;
    end
    chk("ch2_inc0_pulses", 32'(n_ce2), 32'd0);

    // sync with ch0/ch1 active
    wait_locked();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_ce", 32'(ce), 32'd0);
    chk("sync_outclk", 32'(outclk), 32'd0);
    chk("sync_locked", 32'(locked), 32'd1);
    zero_bad = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (ce[0]) zero_bad++;
    end
    chk("sync_ch0_quiet", 32'(zero_bad), 32'd0);
    step();
    chk("sync_ch0_fourth", 32'(ce[0]), 32'd1);
    chk("sync_locked_after", 32'(locked), 32'd1);

    // out-of-range channel on the three-channel instance
    chk("inv_pre_locked", 32'(locked3), 32'd1);
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 8'd255; cfg3_en = 1'b1;
    #1;
    chk("inv_ready", 32'(cfg3_ready), 32'd1);
    step();
    cfg3_valid = 1'b0;
    chk("inv_locked", 32'(locked3), 32'd1);
    chk("inv_no_apply", 32'(cfg3_ready), 32'd1);
    n_ce3 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ce3 != 3'd0 || outclk3 != 3'd0) n_ce3++;
    end
    chk("inv_no_pulses", 32'(n_ce3), 32'd0);

    // async reset pulse mid-run
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(ce), 32'd0);
    chk("arst_outclk", 32'(outclk), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd0);
    chk("arst_locked3", 32'(locked3), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ce != 4'd0 || outclk != 4'd0) zero_bad++;
    end
    chk("post_rst_quiet", 32'(zero_bad), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
